// File: rtl/multicycle_pkg.sv
// ============================================================================
// Module      : multicycle_pkg
// Description : Shared encodings for the multicycle ARM control unit: state
//               codes, mux selects, ALU controls, opcodes and condition codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

    // FSM state encodings (4-bit, visible on the State debug port)
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_EXECI   = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_UNKNOWN = 4'd15;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] REGSRC_NONE = 2'b00;
    localparam logic [1:0] REGSRC_MEM  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_cond_check.sv
// ============================================================================
// Module      : cond_check
// Description : NZCV flags register, ARM condition evaluation and gating of
//               the architectural write enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_check
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       branch,
    input  logic       next_pc,
    input  logic       rd_is_pc,
    output logic       reg_write,
    output logic       mem_write,
    output logic       pc_write
);

    logic [1:0] r_flags_nz;
    logic [1:0] r_flags_cv;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_cond_ex;

    // The instruction's own condition gates its flag update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags_nz <= 2'b00;
            r_flags_cv <= 2'b00;
        end else begin
            if (flag_w[1] && w_cond_ex) begin
                r_flags_nz <= alu_flags[3:2];
            end
            if (flag_w[0] && w_cond_ex) begin
                r_flags_cv <= alu_flags[1:0];
            end
        end
    end

    assign {w_n, w_z} = r_flags_nz;
    assign {w_c, w_v} = r_flags_cv;

    always_comb begin
        w_cond_ex = 1'b1;
        case (cond)
            COND_EQ: w_cond_ex = w_z;
            COND_NE: w_cond_ex = ~w_z;
            COND_CS: w_cond_ex = w_c;
            COND_CC: w_cond_ex = ~w_c;
            COND_MI: w_cond_ex = w_n;
            COND_PL: w_cond_ex = ~w_n;
            COND_VS: w_cond_ex = w_v;
            COND_VC: w_cond_ex = ~w_v;
            COND_HI: w_cond_ex = w_c & ~w_z;
            COND_LS: w_cond_ex = ~w_c | w_z;
            COND_GE: w_cond_ex = (w_n == w_v);
            COND_LT: w_cond_ex = (w_n != w_v);
            COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: w_cond_ex = w_z | (w_n != w_v);
            default: w_cond_ex = 1'b1;
        endcase
    end

    assign reg_write = reg_w & w_cond_ex;
    assign mem_write = mem_w & w_cond_ex;
    assign pc_write  = next_pc | (branch & w_cond_ex) | (reg_w & w_cond_ex & rd_is_pc);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Moore control FSM for the multicycle ARM core; drives the
//               datapath muxes and gates writes through cond_check.
//               MULTICYCLE_ROTIMM_EN: EXECI selects the rotated immediate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] State
);

    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_l;
    logic       w_is_cmp;
    logic       w_next_pc;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_branch;
    logic       w_alu_op;
    logic [1:0] w_flag_w;

    assign w_i      = Funct[5];
    assign w_cmd    = Funct[4:1];
    assign w_s      = Funct[0];
    assign w_l      = Funct[0];
    assign w_is_cmp = (w_cmd == CMD_CMP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_UNKNOWN;
        case (r_state)
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_DP:   w_state_next = w_i ? S_EXECI : S_EXECR;
                    OP_MEM:  w_state_next = S_MEMADR;
                    OP_BR:   w_state_next = S_BRANCH;
                    default: w_state_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR: w_state_next = w_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  w_state_next = S_ALUWB;
            S_MEMWB,
            S_MEMWR,
            S_ALUWB,
            S_BRANCH: w_state_next = S_FETCH;
            default:  w_state_next = S_UNKNOWN;
        endcase
    end

    // Moore outputs: everything defaults to zero, then each state sets its own.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ImmSrc    = IMM_DP;
        RegSrc    = REGSRC_NONE;
        w_next_pc = 1'b0;
        w_reg_w   = 1'b0;
        w_mem_w   = 1'b0;
        w_branch  = 1'b0;
        w_alu_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                w_next_pc = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_EXTIMM;
                ImmSrc  = IMM_MEM;
                RegSrc  = REGSRC_MEM;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                w_reg_w   = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                w_mem_w = 1'b1;
            end
            S_EXECR: begin
                w_alu_op = 1'b1;
            end
            S_EXECI: begin
                ALUSrcB  = SRCB_EXTIMM;
                w_alu_op = 1'b1;
`ifdef MULTICYCLE_ROTIMM_EN
                ImmSrc   = IMM_MEM;
`else
                ImmSrc   = IMM_DP;
`endif
            end
            S_ALUWB: begin
                w_reg_w = ~w_is_cmp;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_EXTIMM;
                ImmSrc    = IMM_BR;
                ResultSrc = RES_ALURESULT;
                w_branch  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // CV only tracks arithmetic results, so logical ops update NZ alone.
    always_comb begin
        ALUControl = ALU_ADD;
        w_flag_w   = 2'b00;
        if (w_alu_op) begin
            case (w_cmd)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                CMD_CMP: ALUControl = ALU_SUB;
                default: ALUControl = ALU_ADD;
            endcase
            w_flag_w[1] = w_s;
            w_flag_w[0] = w_s & ~ALUControl[1];
        end
    end

    cond_check u_cond_check (
        .clk       (clk),
        .reset_n   (reset_n),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_w    (w_flag_w),
        .reg_w     (w_reg_w),
        .mem_w     (w_mem_w),
        .branch    (w_branch),
        .next_pc   (w_next_pc),
        .rd_is_pc  (Rd == 4'd15),
        .reg_write (RegWrite),
        .mem_write (MemWrite),
        .pc_write  (PCWrite)
    );

    assign State = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed scoreboard bench for multicycle_ctrl; expected output
//               vectors are queued per cycle and checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [3:0] State;

`ifdef MULTICYCLE_ROTIMM_EN
    localparam logic [1:0] EXECI_IMM = 2'b01;
`else
    localparam logic [1:0] EXECI_IMM = 2'b00;
`endif

    logic [20:0] q_exp[$];
    string       q_tag[$];
    int          n_cmp;
    int          n_bad;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Static mux selects per state; write enables and ALUControl come from the caller.
    function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw,
                                       input logic memw, input logic regw,
                                       input logic [1:0] alu);
        logic       irw;
        logic       adr;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [1:0] rs;
        irw = 1'b0; adr = 1'b0; res = 2'b00; sa = 2'b00; sb = 2'b00; imm = 2'b00; rs = 2'b00;
        case (st)
            4'd0: begin irw = 1'b1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
            4'd1: begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
            4'd2: begin sb = 2'b01; imm = 2'b01; rs = 2'b10; end
            4'd3: begin adr = 1'b1; end
            4'd4: begin res = 2'b01; end
            4'd5: begin adr = 1'b1; end
            4'd7: begin sb = 2'b01; imm = EXECI_IMM; end
            4'd9: begin sa = 2'b10; sb = 2'b01; imm = 2'b10; res = 2'b10; end
            default: begin end
        endcase
        return {st, pcw, memw, regw, irw, adr, res, sa, sb, imm, rs, alu};
    endfunction

    task automatic push(input string tag, input logic [3:0] st, input logic pcw,
                        input logic memw, input logic regw, input logic [1:0] alu);
        q_exp.push_back(mk(st, pcw, memw, regw, alu));
        q_tag.push_back(tag);
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic pcw,
                        input logic memw, input logic regw, input logic [1:0] alu);
        push(tag, st, pcw, memw, regw, alu);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r, input logic [3:0] fl);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
    endtask

    task automatic fetch_decode(input string tag);
        step({tag, "_fetch"}, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step({tag, "_decode"}, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // Monitor: compares one queued vector against the DUT mid-cycle.
    initial begin
        logic [20:0] exp_v;
        logic [20:0] act_v;
        string       tag;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                exp_v = q_exp.pop_front();
                tag   = q_tag.pop_front();
                act_v = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
                         ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h (st/pcw/memw/regw/irw/adr/res/sa/sb/imm/rs/alu)",
                             tag, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        instr(4'h0, 2'b00, 6'b000000, 4'd0, 4'h0);
        @(posedge clk);
        #1;
        step("rst_hold", 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        reset_n = 1'b1;

        // ADD R1,R2,#5
        instr(4'hE, 2'b00, 6'b101000, 4'd1, 4'h0);
        fetch_decode("add");
        step("add_execi", 4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        step("add_aluwb", 4'd8, 1'b0, 1'b0, 1'b1, 2'b00);

        // CMP setting Z, then BEQ taken
        instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
        fetch_decode("cmpz");
        step("cmpz_execr", 4'd6, 1'b0, 1'b0, 1'b0, 2'b01);
        step("cmpz_aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        instr(4'h0, 2'b10, 6'b101000, 4'd0, 4'h0);
        fetch_decode("beq_t");
        step("beq_t_branch", 4'd9, 1'b1, 1'b0, 1'b0, 2'b00);

        // CMP clearing Z, then BEQ not taken
        instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0000);
        fetch_decode("cmpnz");
        step("cmpnz_execr", 4'd6, 1'b0, 1'b0, 1'b0, 2'b01);
        step("cmpnz_aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        instr(4'h0, 2'b10, 6'b101000, 4'd0, 4'h0);
        fetch_decode("beq_n");
        step("beq_n_branch", 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);

        // CMP sets C; ANDS updates NZ only (Z=1) and keeps C; BCS taken
        instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0010);
        fetch_decode("cmpc");
        step("cmpc_execr", 4'd6, 1'b0, 1'b0, 1'b0, 2'b01);
        step("cmpc_aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
        instr(4'hE, 2'b00, 6'b000001, 4'd0, 4'b0100);
        fetch_decode("ands");
        step("ands_execr", 4'd6, 1'b0, 1'b0, 1'b0, 2'b10);
        step("ands_aluwb", 4'd8, 1'b0, 1'b0, 1'b1, 2'b00);
        instr(4'h2, 2'b10, 6'b101000, 4'd0, 4'h0);
        fetch_decode("bcs");
        step("bcs_branch", 4'd9, 1'b1, 1'b0, 1'b0, 2'b00);

        // STRNE with Z=1: walks all states, no memory write
        instr(4'h1, 2'b01, 6'b011000, 4'd2, 4'h0);
        fetch_decode("strne");
        step("strne_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        step("strne_memwr", 4'd5, 1'b0, 1'b0, 1'b0, 2'b00);

        // STR always
        instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'h0);
        fetch_decode("str");
        step("str_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        step("str_memwr", 4'd5, 1'b0, 1'b1, 1'b0, 2'b00);

        // LDR R3
        instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0);
        fetch_decode("ldr");
        step("ldr_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        step("ldr_memrd", 4'd3, 1'b0, 1'b0, 1'b0, 2'b00);
        step("ldr_memwb", 4'd4, 1'b0, 1'b0, 1'b1, 2'b00);

        // LDR PC: writeback also writes the PC
        instr(4'hE, 2'b01, 6'b011001, 4'd15, 4'h0);
        fetch_decode("ldrpc");
        step("ldrpc_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        step("ldrpc_memrd", 4'd3, 1'b0, 1'b0, 1'b0, 2'b00);
        step("ldrpc_memwb", 4'd4, 1'b1, 1'b0, 1'b1, 2'b00);

        // Reset asserted mid-MEMRD
        instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0);
        fetch_decode("ldrrst");
        step("ldrrst_memadr", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        push("ldrrst_memrd", 4'd3, 1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        step("ldrrst_inrst", 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        reset_n = 1'b1;

        // Flags cleared by reset: BEQ not taken, BNE taken
        instr(4'h0, 2'b10, 6'b101000, 4'd0, 4'h0);
        fetch_decode("beq_r");
        step("beq_r_branch", 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);
        instr(4'h1, 2'b10, 6'b101000, 4'd0, 4'h0);
        fetch_decode("bne_r");
        step("bne_r_branch", 4'd9, 1'b1, 1'b0, 1'b0, 2'b00);

        // Undefined opcode traps in UNKNOWN until reset
        instr(4'hE, 2'b11, 6'b111111, 4'd15, 4'hF);
        fetch_decode("unk");
        for (int i = 0; i < 10; i++) begin
            step("unk_hold", 4'd15, 1'b0, 1'b0, 1'b0, 2'b00);
        end
        reset_n = 1'b0;
        #1;
        step("unk_rst", 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        reset_n = 1'b1;

        // Normal operation resumes
        instr(4'hE, 2'b00, 6'b101000, 4'd1, 4'h0);
        fetch_decode("add2");
        step("add2_execi", 4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        step("add2_aluwb", 4'd8, 1'b0, 1'b0, 1'b1, 2'b00);

        for (int i = 0; i < 4 && q_exp.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q_exp.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
